qpsk_demod: RTL and testbench

- Coherent QPSK demodulator. It sits directly downstream of the modulator and consumes its signed 10-bit QPSK sample stream.
- Correlates the samples against a 4-phase local carrier and integrates each channel over one symbol (integrate-and-dump).
- Slices the sign of each channel into I and Q bits, then re-serialises them into a recovered bit stream, I first.
- All logic runs in one clock domain on clk.

---
 rtl/qpsk_demod.sv | 116 +++++++++++
 tb/tb_qpsk_demod.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_demod.sv
// qpsk_demod: coherent QPSK demodulator.
// Correlates the sample stream against a 4-phase local carrier, integrates
// each channel over one symbol (integrate-and-dump), slices the signs and
// serialises the two decisions as a bit stream, I first.
//
// Handshake: a sample is consumed on every rising edge where sample_valid is
// high; there is no backpressure. sym_valid and bit_valid are one-cycle
// strobes with no ready, so downstream logic must take them when offered.
module qpsk_demod #(
    parameter int CYCLES_PER_SYMBOL = 4,
    parameter int ACC_W             = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [9:0]       sample_in,
    input  logic                    sample_valid,
    input  logic                    sym_sync,
    output logic signed [ACC_W-1:0] sym_I,
    output logic signed [ACC_W-1:0] sym_Q,
    output logic                    sym_valid,
    output logic                    bit_out,
    output logic                    bit_valid
);

    localparam int SPS   = 4 * CYCLES_PER_SYMBOL;
    localparam int IDX_W = $clog2(SPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPS - 1);

    logic [IDX_W-1:0]        idx;
    logic [1:0]              phase;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] base_i;
    logic signed [ACC_W-1:0] base_q;
    logic signed [ACC_W-1:0] sum_i;
    logic signed [ACC_W-1:0] sum_q;
    logic                    dump_now;
    logic                    dump_q;
    logic                    pending_q;

    // Correlator datapath: a sync pulse restarts at phase 0 from empty
    // accumulators; the carrier reference only ever adds, subtracts or skips.
    always_comb begin
        sample_ext = {{(ACC_W-10){sample_in[9]}}, sample_in};
        phase      = sym_sync ? 2'd0 : idx[1:0];
        base_i     = sym_sync ? '0 : acc_i;
        base_q     = sym_sync ? '0 : acc_q;
        sum_i      = base_i;
        sum_q      = base_q;
        case (phase)
            2'd0:    sum_i = base_i + sample_ext;
            2'd1:    sum_q = base_q + sample_ext;
            2'd2:    sum_i = base_i - sample_ext;
            default: sum_q = base_q - sample_ext;
        endcase
        dump_now = sample_valid && !sym_sync && (idx == LAST_IDX);
    end

    // Sample index, accumulators and the symbol dump registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            acc_i  <= '0;
            acc_q  <= '0;
            sym_I  <= '0;
            sym_Q  <= '0;
            dump_q <= 1'b0;
        end else begin
            dump_q <= dump_now;
            if (sym_sync) begin
                acc_i <= sample_valid ? sum_i : '0;
                acc_q <= sample_valid ? sum_q : '0;
                idx   <= sample_valid ? IDX_W'(1) : '0;
            end else if (sample_valid) begin
                if (idx == LAST_IDX) begin
                    sym_I <= sum_i;
                    sym_Q <= sum_q;
                    acc_i <= '0;
                    acc_q <= '0;
                    idx   <= '0;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    idx   <= idx + IDX_W'(1);
                end
            end
        end
    end

    // Symbol strobe and serialiser: I decision with sym_valid, Q the cycle
    // after. Zero slices to 1. Dumps are at least SPS cycles apart, so a new
    // I bit never overlaps a pending Q bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_valid <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sym_valid <= dump_q;
            if (dump_q) begin
                bit_out   <= ~sym_I[ACC_W-1];
                bit_valid <= 1'b1;
                pending_q <= 1'b1;
            end else if (pending_q) begin
                bit_out   <= ~sym_Q[ACC_W-1];
                bit_valid <= 1'b1;
                pending_q <= 1'b0;
            end else begin
                bit_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qpsk_demod.sv
// tb_qpsk_demod: scoreboard bench for qpsk_demod (SPS = 16, ACC_W = 15).
module tb_qpsk_demod;

    localparam int ACC_W = 15;
    localparam int SPS   = 16;

    logic                    clk;
    logic                    rst;
    logic signed [9:0]       sample_in;
    logic                    sample_valid;
    logic                    sym_sync;
    logic signed [ACC_W-1:0] sym_I;
    logic signed [ACC_W-1:0] sym_Q;
    logic                    sym_valid;
    logic                    bit_out;
    logic                    bit_valid;

    qpsk_demod #(.CYCLES_PER_SYMBOL(4), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sym_sync     (sym_sync),
        .sym_I        (sym_I),
        .sym_Q        (sym_Q),
        .sym_valid    (sym_valid),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired before the end of the test");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int bit_cnt = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic signed [ACC_W-1:0] exp_i_q[$];
    logic signed [ACC_W-1:0] exp_q_q[$];
    int                      exp_sym_cyc_q[$];
    logic                    exp_bit_q[$];
    int                      exp_bit_cyc_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (sym_valid) begin
                if (exp_i_q.size() == 0) begin
                    check("sym_valid_unexpected", 1, 0);
                end else begin
                    check("sym_I", int'(sym_I), int'(exp_i_q.pop_front()));
                    check("sym_Q", int'(sym_Q), int'(exp_q_q.pop_front()));
                    check("sym_latency", cyc, exp_sym_cyc_q.pop_front());
                end
            end
            if (bit_valid) begin
                bit_cnt++;
                if (exp_bit_q.size() == 0) begin
                    check("bit_valid_unexpected", 1, 0);
                end else begin
                    check("bit_out", int'(bit_out), int'(exp_bit_q.pop_front()));
                    check("bit_latency", cyc, exp_bit_cyc_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic int mod_sample(input int si, input int sq, input int amp, input int p);
        int c;
        int s;
        int v;
        c = (p == 0) ? 1 : (p == 2) ? -1 : 0;
        s = (p == 1) ? 1 : (p == 3) ? -1 : 0;
        v = si * amp * c + sq * amp * s;
        if (v > 511)  v = 511;
        if (v < -512) v = -512;
        return v;
    endfunction

    task automatic send(input int val, input logic sync);
        @(posedge clk);
        #1;
        sample_in    = 10'(val);
        sample_valid = 1'b1;
        sym_sync     = sync;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
            sym_sync     = 1'b0;
        end
    endtask

    // Push the expectation when the last sample is driven: it is consumed on
    // the next edge, and sym_valid follows one edge later.
    task automatic push_expect(input int exp_i, input int exp_q);
        exp_i_q.push_back(ACC_W'(exp_i));
        exp_q_q.push_back(ACC_W'(exp_q));
        exp_sym_cyc_q.push_back(cyc + 2);
        exp_bit_q.push_back(exp_i >= 0);
        exp_bit_cyc_q.push_back(cyc + 2);
        exp_bit_q.push_back(exp_q >= 0);
        exp_bit_cyc_q.push_back(cyc + 3);
    endtask

    task automatic send_symbol(input int si, input int sq, input int amp, input int gap_max,
                               input logic sync_first, input int exp_i, input int exp_q);
        for (int k = 0; k < SPS; k++) begin
            if (k > 0 && gap_max > 0) idle($urandom_range(0, gap_max));
            send(mod_sample(si, sq, amp, k % 4), sync_first && (k == 0));
            if (k == SPS - 1) push_expect(exp_i, exp_q);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        idle(1);
        n = 0;
        while ((exp_i_q.size() != 0 || exp_bit_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        idle(3);
        check({tag, "_sym_left"}, exp_i_q.size(), 0);
        check({tag, "_bit_left"}, exp_bit_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    int si_tab[4] = '{1, -1, -1, 1};
    int sq_tab[4] = '{1, 1, -1, -1};

    initial begin
        rst          = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        sym_sync     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sym_I", int'(sym_I), 0);
        check("rst_sym_Q", int'(sym_Q), 0);
        check("rst_sym_valid", int'(sym_valid), 0);
        check("rst_bit_out", int'(bit_out), 0);
        check("rst_bit_valid", int'(bit_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        // single symbol I=+1 Q=-1 A=100: 800 / -800, bits 1 0
        send_symbol(1, -1, 100, 0, 1'b1, 800, -800);
        drain("single");

        // async reset mid-symbol after a non-zero dump
        for (int k = 0; k < 5; k++) send(mod_sample(-1, 1, 100, k % 4), k == 0);
        @(posedge clk);
        #3;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sym_sync     = 1'b0;
        #1;
        check("arst_sym_I", int'(sym_I), 0);
        check("arst_sym_Q", int'(sym_Q), 0);
        check("arst_sym_valid", int'(sym_valid), 0);
        check("arst_bit_out", int'(bit_out), 0);
        check("arst_bit_valid", int'(bit_valid), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // no sync: the index restarted at 0, so 16 samples must dump
        send_symbol(1, 1, 100, 0, 1'b0, 800, 800);
        drain("post_reset");

        // continuous stream, A=200: bits 11 01 00 10
        bit_cnt = 0;
        for (int s = 0; s < 4; s++)
            send_symbol(si_tab[s], sq_tab[s], 200, 0, s == 0, si_tab[s] * 1600, sq_tab[s] * 1600);
        drain("stream");
        check("stream_bit_count", bit_cnt, 8);

        // same stream with random 0-3 cycle gaps
        bit_cnt = 0;
        for (int s = 0; s < 4; s++)
            send_symbol(si_tab[s], sq_tab[s], 200, 3, s == 0, si_tab[s] * 1600, sq_tab[s] * 1600);
        drain("gapped");
        check("gapped_bit_count", bit_cnt, 8);

        // resync after 7 samples of symbol A; B = (-1,+1) A=50
        for (int k = 0; k < 7; k++) send(mod_sample(1, 1, 100, k % 4), k == 0);
        send_symbol(-1, 1, 50, 0, 1'b1, -400, 400);
        drain("resync");

        // all-zero samples slice to 1,1
        send_symbol(1, 1, 0, 0, 1'b1, 0, 0);
        drain("zero");

        // full swing: I gets -512 and +511 -> 4*(-1023); Q the mirror image
        send_symbol(-1, 1, 512, 0, 1'b1, -4092, 4092);
        drain("full_swing");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
